psum_accumulator_mc: RTL and testbench

Multi-lane partial-sum accumulator for the matrix datapath, sitting between the PE array's column outputs and the requantisation stage. Each accepted beat carries one value per lane. The value is written or added, with optional saturation, into a per-lane storage row indexed by an internal write pointer. When a tile completes, the block drains the accumulated row through a valid/ready stream with per-entry saturation flags, then returns to idle.

---
 rtl/psum_accumulator_mc.sv | 155 +++++++++++++++
 tb/tb_psum_accumulator_mc.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator_mc.sv
// Multi-lane partial-sum accumulator: beats are written or added (optionally saturating)
// into per-lane rows, and a completed tile is drained through a valid/ready stream.
module psum_accumulator_mc #(
    parameter int LANES     = 4,
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [LANES*IN_WIDTH-1:0]  in_data_i,
    input  logic                       in_init_i,
    input  logic                       in_last_i,
    input  logic                       in_tile_done_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [LANES*ACC_WIDTH-1:0] out_data_o,
    output logic [LANES-1:0]           out_sat_o,
    output logic                       out_last_o,
    output logic                       busy_o,
    output logic                       overflow_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t                       r_state;
    state_t                       w_nextState;
    logic [PW-1:0]                r_wrPtr;
    logic [PW-1:0]                r_rdPtr;
    logic [LW-1:0]                r_rowLen;
    logic signed [ACC_WIDTH-1:0]  r_acc [LANES][DEPTH];
    logic [DEPTH-1:0]             r_sat [LANES];
    logic                         r_outValid;
    logic [LANES*ACC_WIDTH-1:0]   r_outData;
    logic [LANES-1:0]             r_outSat;
    logic                         r_outLast;
    logic                         r_overflow;

    logic                         w_accept;
    logic                         w_drainDone;
    logic                         w_loadOut;
    logic signed [IN_WIDTH-1:0]   w_inLane  [LANES];
    logic signed [ACC_WIDTH-1:0]  w_inExt   [LANES];
    logic signed [ACC_WIDTH:0]    w_sum     [LANES];
    logic [ACC_WIDTH-1:0]         w_newAcc  [LANES];
    logic [LANES-1:0]             w_newSat;

    assign in_ready_o     = (r_state == S_IDLE) && rst_n;
    assign busy_o         = (r_state == S_DRAIN);
    assign out_valid_o    = r_outValid;
    assign out_data_o     = r_outData;
    assign out_sat_o      = r_outSat;
    assign out_last_o     = r_outLast;
    assign overflow_err_o = r_overflow;

    assign w_accept    = in_valid_i && in_ready_o;
    assign w_drainDone = r_outValid && out_ready_i && r_outLast;
    assign w_loadOut   = (r_state == S_DRAIN) && (!r_outValid || out_ready_i) && !w_drainDone;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && in_tile_done_i) w_nextState = S_DRAIN;
            S_DRAIN: if (w_drainDone) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // The sum is one bit wider than the accumulator so overflow shows up as a sign disagreement.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_inLane[l] = in_data_i[l*IN_WIDTH +: IN_WIDTH];
            w_inExt[l]  = ACC_WIDTH'(w_inLane[l]);
            w_sum[l]    = {r_acc[l][r_wrPtr][ACC_WIDTH-1], r_acc[l][r_wrPtr]}
                        + {w_inExt[l][ACC_WIDTH-1], w_inExt[l]};
            w_newAcc[l] = w_sum[l][ACC_WIDTH-1:0];
            w_newSat[l] = r_sat[l][r_wrPtr];
            if (in_init_i) begin
                w_newAcc[l] = w_inExt[l];
                w_newSat[l] = 1'b0;
            end else if (SATURATE && (w_sum[l][ACC_WIDTH] != w_sum[l][ACC_WIDTH-1])) begin
                w_newAcc[l] = w_sum[l][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                w_newSat[l] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_rowLen   <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSat   <= '0;
            r_outLast  <= 1'b0;
            r_overflow <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_sat[l] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    r_acc[l][e] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                for (int l = 0; l < LANES; l++) begin
                    r_acc[l][r_wrPtr] <= w_newAcc[l];
                    r_sat[l][r_wrPtr] <= w_newSat[l];
                end
                if (in_last_i || in_tile_done_i) begin
                    r_wrPtr  <= '0;
                    r_rowLen <= {1'b0, r_wrPtr} + LW'(1);
                end else begin
                    r_wrPtr <= r_wrPtr + PW'(1);
                    if (&r_wrPtr) r_overflow <= 1'b1;
                end
                if (in_tile_done_i) r_rdPtr <= '0;
            end

            // Sat flags are cleared only once the whole row has left, so a tile can re-use them.
            if (w_drainDone) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
                for (int l = 0; l < LANES; l++) begin
                    r_sat[l] <= '0;
                end
            end else if (w_loadOut) begin
                r_outValid <= 1'b1;
                r_outLast  <= ({1'b0, r_rdPtr} == (r_rowLen - LW'(1)));
                r_rdPtr    <= r_rdPtr + PW'(1);
                for (int l = 0; l < LANES; l++) begin
                    r_outData[l*ACC_WIDTH +: ACC_WIDTH] <= r_acc[l][r_rdPtr];
                    r_outSat[l] <= r_sat[l][r_rdPtr];
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator_mc.sv
// Self-checking bench for psum_accumulator_mc: hand sequences, a saturation vector table,
// and randomized tiles compared against an arithmetic reference model.
module tb_psum_accumulator_mc;

    localparam int L = 4;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           inValid, inReady, inInit, inLast, inTile;
    logic [127:0]   inData;
    logic           outValid, outReady, outLast, busy, ovfErr;
    logic [127:0]   outData;
    logic [3:0]     outSat;

    logic           bValid, bReady, bInit, bLast, bTile;
    logic [127:0]   bData;
    logic           bOutValid, bOutReady, bOutLast, bBusy, bOvf;
    logic [127:0]   bOutData;
    logic [3:0]     bOutSat;

    psum_accumulator_mc #(.LANES(L), .DEPTH(D), .IN_WIDTH(32), .ACC_WIDTH(32), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(inValid), .in_ready_o(inReady), .in_data_i(inData),
        .in_init_i(inInit), .in_last_i(inLast), .in_tile_done_i(inTile),
        .out_valid_o(outValid), .out_ready_i(outReady), .out_data_o(outData),
        .out_sat_o(outSat), .out_last_o(outLast), .busy_o(busy), .overflow_err_o(ovfErr)
    );

    psum_accumulator_mc #(.LANES(L), .DEPTH(D), .IN_WIDTH(32), .ACC_WIDTH(32), .SATURATE(1'b0)) dutWrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(bValid), .in_ready_o(bReady), .in_data_i(bData),
        .in_init_i(bInit), .in_last_i(bLast), .in_tile_done_i(bTile),
        .out_valid_o(bOutValid), .out_ready_i(bOutReady), .out_data_o(bOutData),
        .out_sat_o(bOutSat), .out_last_o(bOutLast), .busy_o(bBusy), .overflow_err_o(bOvf)
    );

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] mAcc [L][D];
    logic        mSat [L][D];
    int          mWr;
    int          mRowLen;
    logic        mOvf;

    typedef struct {
        logic [31:0] initVal;
        logic [31:0] addVal;
        logic [31:0] expVal;
        logic        expSat;
    } satVec_t;

    satVec_t satTable [8];

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int l = 0; l < L; l++)
            for (int e = 0; e < D; e++) begin
                mAcc[l][e] = '0;
                mSat[l][e] = 1'b0;
            end
        mWr = 0;
        mRowLen = 0;
        mOvf = 1'b0;
    endtask

    task automatic modelClearSat();
        for (int l = 0; l < L; l++)
            for (int e = 0; e < D; e++) mSat[l][e] = 1'b0;
    endtask

    task automatic modelBeat(input logic [127:0] data, input logic init, input logic last, input logic tile);
        logic signed [31:0] a;
        logic signed [31:0] b;
        longint s;
        for (int l = 0; l < L; l++) begin
            a = mAcc[l][mWr];
            b = data[l*32 +: 32];
            s = longint'(a) + longint'(b);
            if (init) begin
                mAcc[l][mWr] = b;
                mSat[l][mWr] = 1'b0;
            end else if (s > 64'sd2147483647) begin
                mAcc[l][mWr] = 32'h7FFFFFFF;
                mSat[l][mWr] = 1'b1;
            end else if (s < -64'sd2147483648) begin
                mAcc[l][mWr] = 32'h80000000;
                mSat[l][mWr] = 1'b1;
            end else begin
                mAcc[l][mWr] = s[31:0];
            end
        end
        if (last || tile) begin
            mRowLen = mWr + 1;
            mWr = 0;
        end else if (mWr == D - 1) begin
            mWr = 0;
            mOvf = 1'b1;
        end else begin
            mWr = mWr + 1;
        end
    endtask

    function automatic logic [127:0] packEntry(input int idx);
        logic [127:0] r;
        for (int l = 0; l < L; l++) r[l*32 +: 32] = mAcc[l][idx];
        return r;
    endfunction

    function automatic logic [3:0] packSat(input int idx);
        logic [3:0] r;
        for (int l = 0; l < L; l++) r[l] = mSat[l][idx];
        return r;
    endfunction

    function automatic logic [31:0] randLane();
        if ($urandom % 2 == 0) return $urandom;
        return 32'($urandom_range(0, 200)) - 32'd100;
    endfunction

    // Inputs are driven 1ns after a rising edge and the beat is taken at the following edge.
    task automatic applyStimulus(input logic [127:0] data, input logic init, input logic last, input logic tile);
        int w;
        w = 0;
        inValid = 1'b1;
        inData  = data;
        inInit  = init;
        inLast  = last;
        inTile  = tile;
        while (!inReady && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checkVal("in_ready_for_beat", inReady, 1);
        @(posedge clk); #1;
        inValid = 1'b0;
        modelBeat(data, init, last, tile);
        checkVal("overflow_flag", ovfErr, mOvf);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            inValid = 1'b0;
            inData  = {$urandom, $urandom, $urandom, $urandom};
            inInit  = 1'($urandom);
            inLast  = 1'($urandom);
            inTile  = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Drains the current tile against the model, optionally throttling out_ready.
    task automatic checkOutput(input bit randReady);
        int idx;
        int cyc;
        bit done;
        bit held;
        logic [127:0] hData;
        logic [3:0]   hSat;
        logic         hLast;
        idx = 0; cyc = 0; done = 0; held = 0;
        hData = '0; hSat = '0; hLast = 1'b0;
        while (!done && cyc < 400) begin
            outReady = randReady ? 1'($urandom) : 1'b1;
            checkVal("in_ready_low_in_drain", inReady, 0);
            if (held) begin
                checkVal("stall_data_stable", outData, hData);
                checkVal("stall_sat_stable", outSat, hSat);
                checkVal("stall_last_stable", outLast, hLast);
            end
            held = 0;
            if (outValid) begin
                if (idx >= mRowLen) begin
                    checkVal("extra_drain_entry", idx, mRowLen - 1);
                    done = 1;
                end else begin
                    checkVal("drain_data", outData, packEntry(idx));
                    checkVal("drain_sat", outSat, packSat(idx));
                    checkVal("drain_last", outLast, (idx == mRowLen - 1));
                end
                if (outReady) begin
                    idx++;
                    if (outLast) done = 1;
                end else begin
                    held = 1;
                    hData = outData; hSat = outSat; hLast = outLast;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        outReady = 1'b1;
        checkVal("drain_completed", done, 1);
        checkVal("drain_count", idx, mRowLen);
        checkVal("valid_low_after_drain", outValid, 0);
        checkVal("idle_after_drain", {busy, inReady}, 2'b01);
        modelClearSat();
    endtask

    task automatic waitOutValid();
        int w;
        w = 0;
        while (!outValid && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        checkVal("out_valid_arrives", outValid, 1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] d, e, ip, ap;
        logic [3:0] es;
        int nRows, len;

        satTable[0] = '{32'h7FFFFFF0, 32'h00000020, 32'h7FFFFFFF, 1'b1};
        satTable[1] = '{32'h80000005, 32'hFFFFFFF0, 32'h80000000, 1'b1};
        satTable[2] = '{32'h00000005, 32'h00000003, 32'h00000008, 1'b0};
        satTable[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        satTable[4] = '{32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        satTable[5] = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b1};
        satTable[6] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0};
        satTable[7] = '{32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};

        rst_n = 1'b0; inValid = 1'b0; inData = '0; inInit = 0; inLast = 0; inTile = 0; outReady = 1'b1;
        bValid = 1'b0; bData = '0; bInit = 0; bLast = 0; bTile = 0; bOutReady = 1'b1;
        modelReset();
        #1;
        checkVal("in_ready_in_reset", inReady, 0);
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_outputs", {outValid, outLast, outSat, busy, ovfErr}, 0);
        checkVal("reset_data", outData, 0);
        rst_n = 1'b1;
        #1;
        checkVal("ready_after_reset", inReady, 1);

        // Three rows of four beats; expected entries are 10*l + p + 2.
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 4; p++) begin
                for (int l = 0; l < L; l++) d[l*32 +: 32] = (r == 0) ? 32'(10*l + p) : 32'd1;
                applyStimulus(d, r == 0, p == 3, (r == 2) && (p == 3));
            end
        checkVal("drain_entry_state", {busy, inReady, outValid}, 3'b100);
        @(posedge clk); #1;
        checkVal("first_valid_two_edges", outValid, 1);
        for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < L; l++) e[l*32 +: 32] = 32'(10*l + p + 2);
            checkVal("row_sum_data", outData, e);
            checkVal("row_sum_sat", outSat, 0);
            checkVal("row_sum_last", outLast, p == 3);
            @(posedge clk); #1;
        end
        checkVal("row_sum_back_idle", {outValid, busy, inReady}, 3'b001);
        modelClearSat();

        // Saturation vectors, four lanes per drained entry.
        for (int g = 0; g < 2; g++) begin
            for (int l = 0; l < L; l++) begin
                ip[l*32 +: 32] = satTable[4*g + l].initVal;
                ap[l*32 +: 32] = satTable[4*g + l].addVal;
                e[l*32 +: 32]  = satTable[4*g + l].expVal;
                es[l]          = satTable[4*g + l].expSat;
            end
            applyStimulus(ip, 1'b1, 1'b1, 1'b0);
            applyStimulus(ap, 1'b0, 1'b1, 1'b1);
            waitOutValid();
            checkVal("sat_table_data", outData, e);
            checkVal("sat_table_flags", outSat, es);
            checkVal("sat_table_last", outLast, 1);
            @(posedge clk); #1;
            checkVal("sat_table_done", outValid, 0);
            modelClearSat();
        end

        // Wrapping instance: no clamping and no sat flags.
        bValid = 1'b1; bInit = 1'b1; bLast = 1'b1; bTile = 1'b0;
        bData = {32'h0, 32'h80000000, 32'h12345678, 32'h7FFFFFFF};
        @(posedge clk); #1;
        bInit = 1'b0; bTile = 1'b1;
        bData = {32'h0, 32'h80000000, 32'h00000001, 32'h00000001};
        @(posedge clk); #1;
        bValid = 1'b0; bTile = 1'b0; bLast = 1'b0;
        @(posedge clk); #1;
        checkVal("wrap_valid", bOutValid, 1);
        checkVal("wrap_data", bOutData, {32'h0, 32'h00000000, 32'h12345679, 32'h80000000});
        checkVal("wrap_sat", bOutSat, 0);
        checkVal("wrap_last", bOutLast, 1);
        @(posedge clk); #1;
        checkVal("wrap_done", bOutValid, 0);

        // Randomized tiles with input gaps and throttled drain.
        for (int t = 0; t < 8; t++) begin
            nRows = $urandom_range(1, 3);
            for (int r = 0; r < nRows; r++) begin
                len = $urandom_range(1, D);
                for (int p = 0; p < len; p++) begin
                    if ($urandom % 4 == 0) idleCycles($urandom_range(1, 2));
                    for (int l = 0; l < L; l++) d[l*32 +: 32] = randLane();
                    applyStimulus(d, (r == 0) || ($urandom % 4 == 0), p == len - 1,
                                  (p == len - 1) && (r == nRows - 1));
                end
            end
            checkOutput(1'b1);
        end

        // Row overflow: 17 non-last beats, the 17th lands back on entry 0.
        for (int p = 0; p < 17; p++) begin
            for (int l = 0; l < L; l++) d[l*32 +: 32] = (p == 16) ? 32'd5 : 32'(100 + p);
            applyStimulus(d, p < 16, 1'b0, 1'b0);
            if (p == 14) checkVal("ovf_before_16th", ovfErr, 0);
            if (p == 15) checkVal("ovf_at_16th", ovfErr, 1);
        end
        for (int l = 0; l < L; l++) d[l*32 +: 32] = 32'd1;
        applyStimulus(d, 1'b0, 1'b1, 1'b1);
        waitOutValid();
        checkVal("ovf_entry0_accum", outData, {4{32'd105}});
        checkOutput(1'b0);
        checkVal("ovf_sticky", ovfErr, 1);

        // Reset after two drained entries aborts the drain.
        for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < L; l++) d[l*32 +: 32] = randLane();
            applyStimulus(d, 1'b1, p == 3, p == 3);
        end
        outReady = 1'b1;
        waitOutValid();
        for (int k = 0; k < 2; k++) begin
            checkVal("pre_reset_drain", outData, packEntry(k));
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkVal("ready_low_in_reset", inReady, 0);
        @(posedge clk); #1;
        checkVal("mid_reset_outputs", {outValid, outLast, outSat, busy, ovfErr}, 0);
        checkVal("mid_reset_data", outData, 0);
        rst_n = 1'b1;
        modelReset();
        #1;
        checkVal("idle_after_reset", {inReady, busy}, 2'b10);
        @(posedge clk); #1;
        checkVal("no_output_after_reset", outValid, 0);
        for (int l = 0; l < L; l++) d[l*32 +: 32] = randLane();
        applyStimulus(d, 1'b1, 1'b0, 1'b1);
        checkOutput(1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
